// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - WS2812 frame sequencer: CPU-filled pixel buffer streamed as GRB words
// Define WS2812_BRIGHTNESS_EN to enable the BRIGHT register and the per-channel SCALE stage.
module ws2812_frame_ctrl #(
  parameter int NUM_LEDS     = 16,
  parameter int CLK_FRE      = 25_175_000,
  parameter int LATCH_CYCLES = CLK_FRE / 12_500
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        R_W_n,
  input  logic [2:0]  reg_addr_i,
  input  logic [7:0]  data_i,
  input  logic        frame_cs,
  output logic [7:0]  data_o,
  output logic [23:0] pix_data_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  input  logic        ser_busy_i,
  output logic        busy_o
);

  localparam int            AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int            LW       = $clog2(LATCH_CYCLES + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LEDS - 1);
  localparam logic [8:0]    CNT_MAX  = 9'(NUM_LEDS);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
`ifdef WS2812_BRIGHTNESS_EN
    SCALE,
`endif
    SEND,
    DRAIN,
    LATCH
  } state_e;

  state_e        state_q;
  logic          wr_en;
  logic          busy;
  logic          start_q;
  logic          done_q;
  logic          auto_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] last_q;
  logic [7:0]    r_q;
  logic [7:0]    g_q;
  logic [7:0]    b_q;
  logic [8:0]    cnt_q;
  logic [LW-1:0] lat_q;
  logic [23:0]   pix_data_q;
  logic          pix_valid_q;
  logic [23:0]   mem_q [NUM_LEDS];
  logic [AW-1:0] idx_set_d;
  logic [AW-1:0] idx_inc_d;
  logic [8:0]    cnt_set_d;

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]    bright_q;
  logic [23:0]   raw_q;

  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    return 8'((17'(c) * (17'(b) + 17'd1)) >> 8);
  endfunction
`endif

  assign wr_en       = frame_cs & ~R_W_n;
  // START is registered off the bus; the pending cycle already counts as busy.
  assign busy        = (state_q != IDLE) | start_q;
  assign busy_o      = busy;
  assign pix_data_o  = pix_data_q;
  assign pix_valid_o = pix_valid_q;

  assign idx_set_d = ({24'd0, data_i} >= NUM_LEDS) ? LAST_IDX : AW'(data_i);
  assign idx_inc_d = (idx_q == LAST_IDX) ? '0 : idx_q + AW'(1);
  assign cnt_set_d = (data_i == 8'd0)          ? 9'd1    :
                     ({1'b0, data_i} > CNT_MAX) ? CNT_MAX : {1'b0, data_i};

  always_comb begin
    data_o = 8'h00;
    case (reg_addr_i)
      3'd0:    data_o = {6'd0, auto_q, 1'b0};
      3'd1:    data_o = 8'(idx_q);
      3'd2:    data_o = r_q;
      3'd3:    data_o = g_q;
      3'd4:    data_o = b_q;
      3'd5:    data_o = cnt_q[7:0];
      3'd6:    data_o = {6'd0, done_q, busy};
`ifdef WS2812_BRIGHTNESS_EN
      3'd7:    data_o = bright_q;
`endif
      default: data_o = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q    <= '0;
      r_q      <= 8'h00;
      g_q      <= 8'h00;
      b_q      <= 8'h00;
      auto_q   <= 1'b0;
      cnt_q    <= CNT_MAX;
`ifdef WS2812_BRIGHTNESS_EN
      bright_q <= 8'hFF;
`endif
    end else if (wr_en) begin
      case (reg_addr_i)
        3'd0: auto_q <= data_i[1];
        3'd1: idx_q  <= idx_set_d;
        3'd2: r_q    <= data_i;
        3'd3: g_q    <= data_i;
        3'd4: begin
          b_q   <= data_i;
          idx_q <= idx_inc_d;
        end
        3'd5: cnt_q  <= cnt_set_d;
`ifdef WS2812_BRIGHTNESS_EN
        3'd7: bright_q <= data_i;
`endif
        default: ;
      endcase
    end
  end

  // Pixel buffer contents are never reset; the FSM read below sees the pre-edge value.
  always_ff @(posedge clk_i) begin
    if (wr_en && reg_addr_i == 3'd4) begin
      mem_q[idx_q] <= {g_q, r_q, data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      ptr_q       <= '0;
      last_q      <= '0;
      lat_q       <= '0;
      pix_data_q  <= 24'h0;
      pix_valid_q <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
      raw_q       <= 24'h0;
`endif
    end else begin
      start_q <= wr_en && reg_addr_i == 3'd0 && data_i[0] && !busy;
      if (wr_en && reg_addr_i == 3'd6 && data_i[1]) begin
        done_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start_q) begin
            ptr_q   <= '0;
            last_q  <= AW'(cnt_q - 9'd1);
            state_q <= FETCH;
          end
        end
        FETCH: begin
`ifdef WS2812_BRIGHTNESS_EN
          raw_q       <= mem_q[ptr_q];
          state_q     <= SCALE;
        end
        SCALE: begin
          pix_data_q  <= {scale_ch(raw_q[23:16], bright_q),
                          scale_ch(raw_q[15:8], bright_q),
                          scale_ch(raw_q[7:0], bright_q)};
          pix_valid_q <= 1'b1;
          state_q     <= SEND;
`else
          pix_data_q  <= mem_q[ptr_q];
          pix_valid_q <= 1'b1;
          state_q     <= SEND;
`endif
        end
        SEND: begin
          if (pix_ready_i) begin
            pix_valid_q <= 1'b0;
            ptr_q       <= ptr_q + AW'(1);
            state_q     <= (ptr_q == last_q) ? DRAIN : FETCH;
          end
        end
        DRAIN: begin
          if (!ser_busy_i) begin
            lat_q   <= '0;
            state_q <= LATCH;
          end
        end
        LATCH: begin
          if (lat_q == LAT_LAST) begin
            done_q <= 1'b1;
            if (auto_q) begin
              ptr_q   <= '0;
              last_q  <= AW'(cnt_q - 9'd1);
              state_q <= FETCH;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb/tb_ws2812_frame_ctrl.sv - directed self-checking bench for ws2812_frame_ctrl
module tb_ws2812_frame_ctrl;

  localparam int NL = 16;
  localparam int LC = 20;
`ifdef WS2812_BRIGHTNESS_EN
  localparam int LAT_V = 3;
  localparam int P_GAP = 3;
  localparam int F_GAP = LC + 4;
`else
  localparam int LAT_V = 2;
  localparam int P_GAP = 2;
  localparam int F_GAP = LC + 3;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        R_W_n = 1'b1;
  logic [2:0]  reg_addr_i = 3'd0;
  logic [7:0]  data_i = 8'h00;
  logic        frame_cs = 1'b0;
  logic [7:0]  data_o;
  logic [23:0] pix_data_o;
  logic        pix_valid_o;
  logic        pix_ready_i;
  logic        ser_busy_i = 1'b0;
  logic        busy_o;

  logic rnd_mode = 1'b0;
  logic rdy_fix  = 1'b1;
  logic rdy_rnd  = 1'b1;
  assign pix_ready_i = rnd_mode ? rdy_rnd : rdy_fix;

  ws2812_frame_ctrl #(.NUM_LEDS(NL), .LATCH_CYCLES(LC)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .R_W_n(R_W_n), .reg_addr_i(reg_addr_i),
    .data_i(data_i), .frame_cs(frame_cs), .data_o(data_o), .pix_data_o(pix_data_o),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i), .ser_busy_i(ser_busy_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          hold_viol = 0;
  logic [23:0] words[$];
  int          hs_cyc[$];
  logic        pv_q = 1'b0;
  logic        pr_q = 1'b0;
  logic [23:0] pd_q = 24'h0;

  always @(posedge clk_i) cyc++;

  always @(posedge clk_i) begin
    #1;
    rdy_rnd = 1'($urandom_range(0, 1));
  end

  // Handshakes observed mid-cycle complete at the following rising edge.
  always @(negedge clk_i) begin
    if (pv_q && !pr_q && (!pix_valid_o || pix_data_o != pd_q)) hold_viol++;
    if (pix_valid_o && pix_ready_i) begin
      words.push_back(pix_data_o);
      hs_cyc.push_back(cyc);
    end
    pv_q = pix_valid_o;
    pr_q = pix_ready_i;
    pd_q = pix_data_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk_i); #1;
    reg_addr_i = a; data_i = d; frame_cs = 1'b1; R_W_n = 1'b0;
    @(posedge clk_i); #1;
    frame_cs = 1'b0; R_W_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    reg_addr_i = a;
    #1;
    d = data_o;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (words.size() < n && k < budget) begin
      @(posedge clk_i); #1; k++;
    end
    if (words.size() < n) check("words_timeout", words.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy_o && k < budget) begin
      @(posedge clk_i); #1; k++;
    end
    if (busy_o) check("idle_timeout", 1, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int         k;
    int         base;
    logic [7:0] exp_rst[7];
    exp_rst = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd16, 8'd0};

    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    // Reset state
    for (int i = 0; i < 7; i++) begin
      rd(3'(i), d);
      check($sformatf("rst_reg%0d", i), d, exp_rst[i]);
    end
    rd(3'd7, d);
`ifdef WS2812_BRIGHTNESS_EN
    check("rst_bright", d, 8'hFF);
`else
    check("rst_reg7", d, 8'h00);
`endif
    check("rst_valid", pix_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_pix", pix_data_o, 24'h0);

    // Single pixel frame: latency, word, INDEX advance, DONE timing
    wr(3'd1, 8'd0);
    wr(3'd2, 8'h12);
    wr(3'd3, 8'h34);
    wr(3'd4, 8'h56);
    rd(3'd1, d);
    check("index_after_b", d, 8'd1);
    wr(3'd5, 8'd1);
    ser_busy_i = 1'b1;
    words.delete();
    wr(3'd0, 8'h01);
    check("busy_after_start", busy_o, 1'b1);
    check("valid_at_n", pix_valid_o, 1'b0);
    for (int i = 1; i <= LAT_V; i++) begin
      @(posedge clk_i); #1;
      check($sformatf("valid_n%0d", i), pix_valid_o, (i == LAT_V) ? 1'b1 : 1'b0);
    end
    wait_words(1, 50);
    check("single_word", words.size() > 0 ? words[0] : 24'hx, 24'h341256);
    repeat (3) @(posedge clk_i);
    #1 ser_busy_i = 1'b0;
    repeat (LC) @(posedge clk_i);
    #1;
    rd(3'd6, d);
    check("done_before_term", d[1], 1'b0);
    @(posedge clk_i); #1;
    rd(3'd6, d);
    check("done_at_term", d[1], 1'b1);
    check("idle_after_frame", busy_o, 1'b0);
    check("single_word_count", words.size(), 1);
    wr(3'd6, 8'h02);
    rd(3'd6, d);
    check("done_cleared", d, 8'h00);

    // Full buffer with random backpressure
    wr(3'd1, 8'd0);
    wr(3'd3, 8'h00);
    for (int i = 0; i < NL; i++) begin
      wr(3'd2, 8'(i));
      wr(3'd4, ~8'(i));
    end
    rd(3'd1, d);
    check("index_wrap", d, 8'd0);
    wr(3'd5, 8'd16);
    words.delete();
    hold_viol = 0;
    rnd_mode = 1'b1;
    wr(3'd0, 8'h01);
    wait_words(NL, 600);
    wait_idle(200);
    rnd_mode = 1'b0;
    check("full_count", words.size(), NL);
    for (int i = 0; i < NL; i++) begin
      check($sformatf("full_word%0d", i), i < words.size() ? words[i] : 24'hx,
            {8'h00, 8'(i), ~8'(i)});
    end
    check("hold_stable", hold_viol, 0);

    // AUTO restart, then clear AUTO mid-frame
    wr(3'd5, 8'd2);
    words.delete();
    hs_cyc.delete();
    wr(3'd0, 8'h03);
    wait_words(6, 300);
    check("auto_word4", words.size() > 4 ? words[4] : 24'hx, 24'h0000FF);
    check("auto_word5", words.size() > 5 ? words[5] : 24'hx, 24'h0001FE);
    check("pixel_gap", hs_cyc.size() > 1 ? hs_cyc[1] - hs_cyc[0] : -1, P_GAP);
    check("frame_gap", hs_cyc.size() > 2 ? hs_cyc[2] - hs_cyc[1] : -1, F_GAP);
    k = 0;
    while (words.size() % 2 == 0 && k < 200) begin
      @(posedge clk_i); #1; k++;
    end
    base = words.size();
    check("auto_odd_seen", base % 2, 1);
    wr(3'd0, 8'h00);
    wait_idle(200);
    repeat (60) @(posedge clk_i);
    #1;
    check("auto_stop_words", words.size(), base + 1);
    check("auto_stop_idle", busy_o, 1'b0);

    // START while busy, INDEX clamp, COUNT write while busy
    words.delete();
    wr(3'd0, 8'h01);
    wr(3'd0, 8'h01);
    wr(3'd1, 8'd200);
    wr(3'd5, 8'd3);
    wait_idle(200);
    repeat (60) @(posedge clk_i);
    #1;
    check("no_extra_frame", words.size(), 2);
    rd(3'd1, d);
    check("index_clamp", d, 8'd15);
    rd(3'd5, d);
    check("count_reads_new", d, 8'd3);
    wr(3'd5, 8'd0);
    rd(3'd5, d);
    check("count_clamp_lo", d, 8'd1);
    wr(3'd5, 8'd200);
    rd(3'd5, d);
    check("count_clamp_hi", d, 8'd16);

    // Brightness
    wr(3'd7, 8'h7F);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'h80);
    wr(3'd3, 8'hFF);
    wr(3'd4, 8'h01);
    wr(3'd5, 8'd1);
    words.delete();
    wr(3'd0, 8'h01);
    wait_words(1, 50);
    wait_idle(200);
`ifdef WS2812_BRIGHTNESS_EN
    check("bright_word", words.size() > 0 ? words[0] : 24'hx, 24'h7F4000);
    rd(3'd7, d);
    check("bright_reg", d, 8'h7F);
`else
    check("plain_word", words.size() > 0 ? words[0] : 24'hx, 24'hFF8001);
    rd(3'd7, d);
    check("reg7_zero", d, 8'h00);
`endif

    // Asynchronous reset mid-frame
    rdy_fix = 1'b0;
    wr(3'd0, 8'h01);
    k = 0;
    while (!pix_valid_o && k < 20) begin
      @(posedge clk_i); #1; k++;
    end
    check("valid_before_reset", pix_valid_o, 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    check("reset_drops_valid", pix_valid_o, 1'b0);
    check("reset_drops_busy", busy_o, 1'b0);
    rd(3'd5, d);
    check("reset_count", d, 8'd16);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    rdy_fix = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
